// File: rtl/baud_ctrl_if.sv
// Baud controller bus: configuration request, busy/start status in,
// active selection, period count and tick pulses.
interface baud_ctrl_if #(
  parameter int unsigned KW = 19
);
  logic [3:0]    baud_val_in;
  logic          cfg_we;
  logic          tx_busy;
  logic          rx_busy;
  logic          rx_start;
  logic [KW-1:0] k;
  logic [3:0]    baud_val;
  logic          cfg_pending;
  logic          cfg_err;
  logic          tx_tick;
  logic          rx_tick;

  // Requesting side: software/UART datapath plus the baud_dec lookup
  modport master (
    output baud_val_in, cfg_we, tx_busy, rx_busy, rx_start, k,
    input  baud_val, cfg_pending, cfg_err, tx_tick, rx_tick
  );

  // Controller side
  modport slave (
    input  baud_val_in, cfg_we, tx_busy, rx_busy, rx_start, k,
    output baud_val, cfg_pending, cfg_err, tx_tick, rx_tick
  );
endinterface

// File: rtl/baud_ctrl.sv
// Baud timing controller: holds the active baud selection, defers changes
// until TX and RX are idle, and generates TX bit ticks and RX mid-bit ticks.
module baud_ctrl #(
  parameter int unsigned KW = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  baud_ctrl_if.slave  ctrl
);

  localparam logic [3:0] BAUD_RST = 4'b0100;
  localparam logic [3:0] CODE_MAX = 4'b1011;

  logic [3:0]    r_baud;
  logic [3:0]    r_pend;
  logic          r_pending;
  logic          r_cfg_err;
  logic          r_tx_tick;
  logic          r_rx_tick;
  logic [KW-1:0] r_tx_cnt;
  logic [KW-1:0] r_rx_cnt;
  logic          r_rx_half;

  logic [KW-1:0] w_keff;
  logic [KW-1:0] w_khalf;
  logic          w_code_ok;
  logic          w_apply;

  logic [3:0]    w_baud_nxt;
  logic [3:0]    w_pend_nxt;
  logic          w_pending_nxt;
  logic          w_cfg_err_nxt;
  logic          w_tx_tick_nxt;
  logic          w_rx_tick_nxt;
  logic [KW-1:0] w_tx_cnt_nxt;
  logic [KW-1:0] w_rx_cnt_nxt;
  logic          w_rx_half_nxt;

  // Effective period (minimum 2) and half period, plus the apply condition
  always_comb begin
    w_keff    = (ctrl.k < KW'(2)) ? KW'(2) : ctrl.k;
    w_khalf   = w_keff >> 1;
    w_code_ok = (ctrl.baud_val_in <= CODE_MAX);
    w_apply   = r_pending & ~ctrl.tx_busy & ~ctrl.rx_busy & ~r_rx_half & ~ctrl.cfg_we;
  end

  // Next-state: config capture, TX/RX counters, then apply overrides all
  always_comb begin
    w_baud_nxt    = r_baud;
    w_pend_nxt    = r_pend;
    w_pending_nxt = r_pending;
    w_cfg_err_nxt = 1'b0;
    w_tx_tick_nxt = 1'b0;
    w_rx_tick_nxt = 1'b0;
    w_tx_cnt_nxt  = '0;
    w_rx_cnt_nxt  = '0;
    w_rx_half_nxt = r_rx_half;

    if (ctrl.cfg_we) begin
      if (w_code_ok) begin
        w_pend_nxt    = ctrl.baud_val_in;
        w_pending_nxt = 1'b1;
      end else begin
        w_cfg_err_nxt = 1'b1;
      end
    end

    // >= rather than == so a stray count above the period still wraps
    if (ctrl.tx_busy) begin
      if (r_tx_cnt >= w_keff - KW'(1)) begin
        w_tx_tick_nxt = 1'b1;
      end else begin
        w_tx_cnt_nxt = r_tx_cnt + KW'(1);
      end
    end

    // Start edge resyncs to a half period, then full periods while busy
    if (ctrl.rx_start) begin
      w_rx_half_nxt = 1'b1;
    end else if (r_rx_half) begin
      if (r_rx_cnt >= w_khalf - KW'(1)) begin
        w_rx_tick_nxt = 1'b1;
        w_rx_half_nxt = 1'b0;
      end else begin
        w_rx_cnt_nxt = r_rx_cnt + KW'(1);
      end
    end else if (ctrl.rx_busy) begin
      if (r_rx_cnt >= w_keff - KW'(1)) begin
        w_rx_tick_nxt = 1'b1;
      end else begin
        w_rx_cnt_nxt = r_rx_cnt + KW'(1);
      end
    end

    if (w_apply) begin
      w_baud_nxt    = r_pend;
      w_pending_nxt = 1'b0;
      w_tx_cnt_nxt  = '0;
      w_rx_cnt_nxt  = '0;
      w_rx_half_nxt = 1'b0;
      w_tx_tick_nxt = 1'b0;
      w_rx_tick_nxt = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud    <= BAUD_RST;
      r_pend    <= '0;
      r_pending <= 1'b0;
      r_cfg_err <= 1'b0;
      r_tx_tick <= 1'b0;
      r_rx_tick <= 1'b0;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_rx_half <= 1'b0;
    end else begin
      r_baud    <= w_baud_nxt;
      r_pend    <= w_pend_nxt;
      r_pending <= w_pending_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      r_tx_tick <= w_tx_tick_nxt;
      r_rx_tick <= w_rx_tick_nxt;
      r_tx_cnt  <= w_tx_cnt_nxt;
      r_rx_cnt  <= w_rx_cnt_nxt;
      r_rx_half <= w_rx_half_nxt;
    end
  end

  assign ctrl.baud_val    = r_baud;
  assign ctrl.cfg_pending = r_pending;
  assign ctrl.cfg_err     = r_cfg_err;
  assign ctrl.tx_tick     = r_tx_tick;
  assign ctrl.rx_tick     = r_rx_tick;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: config vector table, directed tick
// timing sequences, async reset, and randomized traffic against a model.
module tb_baud_ctrl;

  localparam int unsigned KW = 19;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  baud_ctrl_if #(.KW(KW)) bus ();

  baud_ctrl #(.KW(KW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (bus)
  );

  always #5 clk = ~clk;

  // k source: either a forced value or a small baud_dec lookup table
  logic          k_mode;
  logic [KW-1:0] k_force;
  int unsigned   k_tab [16];

  always_comb bus.k = k_mode ? KW'(k_tab[bus.baud_val]) : k_force;

  int n_vec = 0;
  int n_err = 0;
  int got_q[$];
  int exp_q[$];

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    logic       we;
    logic [3:0] code;
    logic       txb;
    logic       rxb;
    logic       st;
    int         e_baud;
    int         e_pend;
    int         e_err;
  } vec_t;

  vec_t vq[$];

  task automatic set_in(input logic we, input logic [3:0] code, input logic txb,
                        input logic rxb, input logic st);
    bus.cfg_we      = we;
    bus.baud_val_in = code;
    bus.tx_busy     = txb;
    bus.rx_busy     = rxb;
    bus.rx_start    = st;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_tx(input int n);
    got_q.delete();
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      if (bus.tx_tick) got_q.push_back(e);
    end
  endtask

  // rx_start at edge 0, rx_busy from then on; optional second start at edge 'restart'
  task automatic run_rx(input int n, input int restart);
    got_q.delete();
    bus.rx_start = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_start = 1'b0;
    bus.rx_busy  = 1'b1;
    for (int e = 1; e <= n; e++) begin
      if (e == restart) bus.rx_start = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_start = 1'b0;
      if (bus.rx_tick) got_q.push_back(e);
    end
  endtask

  task automatic check_ticks(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_edge%0d", name, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
  endtask

  // Behavioural model state (edge counts since reference events)
  int m_baud, m_pend, m_pending, m_err, m_txt, m_rxt;
  int tx_n, rx_h, rx_m, rx_p;

  task automatic model_reset();
    m_baud = 4; m_pend = 0; m_pending = 0; m_err = 0; m_txt = 0; m_rxt = 0;
    tx_n = 0; rx_h = 0; rx_m = 0; rx_p = 0;
  endtask

  task automatic model_edge();
    int kv, keff, khalf;
    bit apply;
    kv    = int'(k_tab[m_baud]);
    keff  = (kv < 2) ? 2 : kv;
    khalf = keff / 2;
    apply = (m_pending != 0) && !bus.tx_busy && !bus.rx_busy && (rx_h == 0) && !bus.cfg_we;
    m_err = (bus.cfg_we && int'(bus.baud_val_in) > 11) ? 1 : 0;
    if (bus.cfg_we && int'(bus.baud_val_in) <= 11) begin
      m_pend    = int'(bus.baud_val_in);
      m_pending = 1;
    end
    if (apply) begin
      m_baud = m_pend; m_pending = 0;
      tx_n = 0; rx_h = 0; rx_m = 0; rx_p = 0; m_txt = 0; m_rxt = 0;
    end else begin
      if (bus.tx_busy) begin
        tx_n++;
        m_txt = (tx_n % keff == 0) ? 1 : 0;
      end else begin
        tx_n = 0; m_txt = 0;
      end
      if (bus.rx_start) begin
        rx_h = 1; rx_m = 0; m_rxt = 0;
      end else if (rx_h != 0) begin
        rx_m++;
        if (rx_m == khalf) begin
          m_rxt = 1; rx_h = 0; rx_p = 0;
        end else begin
          m_rxt = 0;
        end
      end else if (bus.rx_busy) begin
        rx_p++;
        m_rxt = (rx_p % keff == 0) ? 1 : 0;
      end else begin
        rx_p = 0; m_rxt = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) k_tab[i] = 3;
    k_tab[0] = 0;  k_tab[1] = 1;  k_tab[2] = 2;  k_tab[3] = 3;
    k_tab[4] = 4;  k_tab[5] = 5;  k_tab[6] = 6;  k_tab[7] = 7;
    k_tab[8] = 8;  k_tab[9] = 9;  k_tab[10] = 10; k_tab[11] = 13;
    k_mode  = 1'b0;
    k_force = KW'(868);

    // Config vectors: {we, code, tx_busy, rx_busy, rx_start, baud, pending, err}
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4,  0, 0});
    vq.push_back('{1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 4,  1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4,  1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4,  1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4,  1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 8,  0, 0});
    vq.push_back('{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 8,  1, 0});
    vq.push_back('{1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 8,  1, 0});
    vq.push_back('{1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 8,  1, 1});
    vq.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8,  1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10, 0, 0});
    vq.push_back('{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 10, 0, 1});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10, 0, 0});
    vq.push_back('{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 10, 1, 0});
    vq.push_back('{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 10, 1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 5,  0, 0});
    vq.push_back('{1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 5,  1, 0});
    vq.push_back('{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 5,  1, 1});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 11, 0, 0});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 11, 0, 0});
    vq.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 11, 1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 11, 1, 0});
    vq.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 11, 1, 0});

    // Reset state
    do_reset();
    check("reset_baud",    int'(bus.baud_val),    4);
    check("reset_pending", int'(bus.cfg_pending), 0);
    check("reset_err",     int'(bus.cfg_err),     0);
    check("reset_txtick",  int'(bus.tx_tick),     0);
    check("reset_rxtick",  int'(bus.rx_tick),     0);

    // Config table
    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].we, vq[i].code, vq[i].txb, vq[i].rxb, vq[i].st);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_baud", i),    int'(bus.baud_val),    vq[i].e_baud);
      check($sformatf("tbl%0d_pending", i), int'(bus.cfg_pending), vq[i].e_pend);
      check($sformatf("tbl%0d_err", i),     int'(bus.cfg_err),     vq[i].e_err);
    end

    // TX ticks with k = 868
    do_reset();
    k_force = KW'(868);
    check("tx868_baud", int'(bus.baud_val), 4);
    bus.tx_busy = 1'b1;
    run_tx(2610);
    exp_q = {868, 1736, 2604};
    check_ticks("tx868");

    // RX ticks with k = 109, single start
    do_reset();
    k_force = KW'(109);
    run_rx(280, 0);
    exp_q = {54, 163, 272};
    check_ticks("rx109");

    // RX resync at edge 100
    do_reset();
    run_rx(270, 100);
    exp_q = {54, 154, 263};
    check_ticks("rx109_resync");

    // Degenerate periods
    do_reset();
    k_force = KW'(0);
    bus.tx_busy = 1'b1;
    run_tx(10);
    exp_q = {2, 4, 6, 8, 10};
    check_ticks("tx_k0");

    do_reset();
    k_force = KW'(1);
    run_rx(9, 0);
    exp_q = {1, 3, 5, 7, 9};
    check_ticks("rx_k1");

    // Async reset mid-frame with a pending request
    do_reset();
    k_force = KW'(2);
    set_in(1'b1, 4'd8, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    set_in(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    bus.rx_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_pending_before", int'(bus.cfg_pending), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_baud",    int'(bus.baud_val),    4);
    check("midrst_pending", int'(bus.cfg_pending), 0);
    check("midrst_err",     int'(bus.cfg_err),     0);
    check("midrst_txtick",  int'(bus.tx_tick),     0);
    check("midrst_rxtick",  int'(bus.rx_tick),     0);
    set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_baud_after",    int'(bus.baud_val),    4);
    check("midrst_pending_after", int'(bus.cfg_pending), 0);

    // Randomized traffic against the model, k from the lookup table
    k_mode = 1'b1;
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 14) == 0) bus.tx_busy = ~bus.tx_busy;
      if ($urandom_range(0, 14) == 0) bus.rx_busy = ~bus.rx_busy;
      bus.rx_start    = ($urandom_range(0, 24) == 0);
      bus.cfg_we      = ($urandom_range(0, 19) == 0);
      bus.baud_val_in = 4'($urandom_range(0, 15));
      model_edge();
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_baud", c),    int'(bus.baud_val),    m_baud);
      check($sformatf("rnd%0d_pending", c), int'(bus.cfg_pending), m_pending);
      check($sformatf("rnd%0d_err", c),     int'(bus.cfg_err),     m_err);
      check($sformatf("rnd%0d_txtick", c),  int'(bus.tx_tick),     m_txt);
      check($sformatf("rnd%0d_rxtick", c),  int'(bus.rx_tick),     m_rxt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/baud_ctrl.md
# baud_ctrl

Baud timing controller for the UART SoC. It owns the active baud selection and drives the `baud_dec` lookup. It turns the returned period count `k` into single-cycle bit ticks for the transmitter, and into start-aligned mid-bit sample ticks for the receiver. It defers software baud changes until both TX and RX are idle, so no frame is ever split across two rates.

## Interface
- KW, 19, width of period count `k` and of internal counters
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- baud_val_in  in  4  requested baud selection code
- cfg_we  in  1  one-cycle pulse: request change to `baud_val_in`
- tx_busy  in  1  transmitter is shifting a frame
- rx_busy  in  1  receiver is assembling a frame
- rx_start  in  1  one-cycle pulse: falling start edge detected on RX line
- k  in  KW  period count returned by `baud_dec` for `baud_val`
- baud_val  out  4  active selection, drives `baud_dec`
- cfg_pending  out  1  a requested change is waiting for idle
- cfg_err  out  1  one-cycle pulse: rejected code (4'b1100–4'b1111)
- tx_tick  out  1  one-cycle pulse: TX bit boundary
- rx_tick  out  1  one-cycle pulse: RX sample point

## Operation
**Config registers**
- `baud_reg` drives `baud_val`.
- `pend_reg` and the `pending` flag drive `cfg_pending`.
- Reset values:
  - `baud_reg` = 4'b0100 (9600)
  - `pend_reg` = 0
  - `pending` = 0
  - `cfg_err` = 0
  - both ticks = 0
  - all counters = 0
  - `rx_half` = 0
- `cfg_we` with a valid code (≤ 4'b1011): `pend_reg` ← `baud_val_in`, `pending` ← 1. A second request before apply overwrites the first (last write wins).
- `cfg_we` with code ≥ 4'b1100: the request is ignored; `cfg_err` = 1 for exactly one cycle; `pending` and `pend_reg` are unchanged.
- Apply: on any edge where `pending`=1, `tx_busy`=0, `rx_busy`=0, `rx_half`=0 and `cfg_we`=0:
  - `baud_reg` ← `pend_reg`, `pending` ← 0
  - `tx_cnt` and `rx_cnt` ← 0, `rx_half` ← 0, both ticks ← 0
- `cfg_we` in the same cycle as an apply condition: the write wins and the apply is deferred one cycle, using the new value.

**Effective period**
- `keff` = (`k` < 2) ? 2 : `k`
- `khalf` = `keff` >> 1 (floor; e.g. 109 → 54, 868 → 434)
- All compares are KW-bit unsigned.

**TX counter**
- While `tx_busy`=0: `tx_cnt` is held at 0 and `tx_tick` = 0.
- While `tx_busy`=1: `tx_cnt` increments each edge.
- When `tx_cnt` = `keff`−1: `tx_cnt` ← 0 and `tx_tick` ← 1 (registered), then 0 on the next edge.

**RX counter**
- `rx_start` sampled high: `rx_cnt` ← 0, `rx_half` ← 1. This applies even if `rx_busy`=1 (resync).
- Counting is enabled while `rx_busy`=1 or `rx_half`=1. Otherwise `rx_cnt` is held at 0.
- `rx_half`=1 and `rx_cnt` = `khalf`−1: `rx_tick` ← 1, `rx_cnt` ← 0, `rx_half` ← 0.
- `rx_half`=0, enabled, and `rx_cnt` = `keff`−1: `rx_tick` ← 1, `rx_cnt` ← 0.
- `rx_start` and a terminal count on the same edge: `rx_start` wins, with no tick.

**Reset**
- Asserting `reset_n` low at any time clears all state immediately (asynchronous), including any pending request.
- Deassertion is synchronized externally.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `tx_tick`: first pulse in the cycle after the `keff`-th consecutive edge with `tx_busy`=1; then every `keff` cycles.
- `rx_tick`: first pulse in the cycle after the `khalf`-th edge following the `rx_start` edge; then every `keff` cycles while `rx_busy`=1.
- `cfg_pending`: rises 1 cycle after `cfg_we`. Falls, and `baud_val` changes, 1 cycle after the apply edge.
- `k` from `baud_dec` is combinational from `baud_val`. It is valid in the cycle after apply, and counters restart from 0, so no old/new mix can occur.
- `cfg_err`: 1 cycle after the `cfg_we` edge, width 1.

## Test plan
- Reset, `tx_busy`=1 held, with `k`=868: `tx_tick` pulses at cycles 868, 1736, 2604 after the first busy edge; `baud_val`=4'b0100 out of reset.
- `rx_start` pulse, then `rx_busy`=1, with `k`=109: `rx_tick` after 54 edges, then at +109 and +218. A second `rx_start` at edge 100 restarts the half count, with no tick at 163.
- `cfg_we`=4'b1000 while `tx_busy`=1:
  - `cfg_pending`=1 and `baud_val` stays 4'b0100 until `tx_busy` and `rx_busy` are both 0.
  - One cycle after that apply edge, `baud_val`=4'b1000.
- `cfg_we` 4'b0011, then 4'b1010 while busy: the apply loads 4'b1010. `cfg_we`=4'b1101 gives a 1-cycle `cfg_err` and no change to `pending` or `baud_val`.
- `k`=0 or 1 forced: `tx_tick` every 2 cycles; `rx_tick` 1 edge after `rx_start`.
- `reset_n` low mid-frame with `pending`=1: all outputs 0 immediately, `baud_val`=4'b0100, `pending` lost.
